// File: rtl/timer_digit_loader_pkg.sv
// Shared types and constants for the keypad-driven MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX           = 4'd9;
    localparam bcd_t SEC_TENS_WRAP_DEF = 4'd5;
    localparam int   MAX_DIGITS_DEF    = 4;

    function automatic logic is_bcd(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/timer_digit_loader_if.sv
// Keypad/control inputs and BCD display/status outputs of the timer digit loader.
interface timer_digit_loader_if import timer_pkg::*; ();

    logic       key_valid;
    bcd_t       key_digit;
    logic       start;
    logic       stop;
    logic       door_open;
    logic       tick_1hz;
    bcd_t       min_tens;
    bcd_t       min_ones;
    bcd_t       sec_tens;
    bcd_t       sec_ones;
    logic [2:0] digit_count;
    logic       running;
    logic       paused;
    logic       done;

    modport master (
        output key_valid, key_digit, start, stop, door_open, tick_1hz,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_count,
               running, paused, done
    );

    modport slave (
        input  key_valid, key_digit, start, stop, door_open, tick_1hz,
        output min_tens, min_ones, sec_tens, sec_ones, digit_count,
               running, paused, done
    );

endinterface

// File: rtl/timer_digit_loader_bcd_digit_down.sv
// One BCD digit of a ripple-borrow down-counter; wraps to i_wrap when borrowing from zero.
module bcd_digit_down import timer_pkg::*; (
    input  bcd_t i_digit,
    input  logic i_borrow_in,
    input  bcd_t i_wrap,
    output bcd_t o_digit,
    output logic o_borrow_out
);

    // Decrement by one when a borrow arrives, passing the borrow up on zero.
    always_comb begin
        o_digit      = i_digit;
        o_borrow_out = 1'b0;
        if (i_borrow_in) begin
            if (i_digit == 4'd0) begin
                o_digit      = i_wrap;
                o_borrow_out = 1'b1;
            end else begin
                o_digit      = i_digit - 4'd1;
                o_borrow_out = 1'b0;
            end
        end else begin
            o_digit      = i_digit;
            o_borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/timer_digit_loader.sv
// Shifts keypad digits into an MM:SS BCD register and counts it down on 1 Hz ticks.
module timer_digit_loader import timer_pkg::*; #(
    parameter int   MAX_DIGITS    = MAX_DIGITS_DEF,
    parameter bcd_t SEC_TENS_WRAP = SEC_TENS_WRAP_DEF
) (
    input  logic                  clock,
    input  logic                  clear,
    timer_digit_loader_if.slave   io_tmr
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t     r_state;
    state_t     w_state_next;
    bcd_t       r_mt, r_mo, r_st, r_so;
    bcd_t       w_mt_next, w_mo_next, w_st_next, w_so_next;
    logic [2:0] r_count;
    logic [2:0] w_count_next;
    logic       r_running, r_paused, r_done;

    bcd_t       w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_b_so, w_b_st, w_b_mo, w_b_mt;
    logic       w_time_zero;
    logic       w_dec_zero;

    bcd_digit_down u_dec_so (
        .i_digit     (r_so),
        .i_borrow_in (1'b1),
        .i_wrap      (BCD_MAX),
        .o_digit     (w_dec_so),
        .o_borrow_out(w_b_so)
    );

    bcd_digit_down u_dec_st (
        .i_digit     (r_st),
        .i_borrow_in (w_b_so),
        .i_wrap      (SEC_TENS_WRAP),
        .o_digit     (w_dec_st),
        .o_borrow_out(w_b_st)
    );

    bcd_digit_down u_dec_mo (
        .i_digit     (r_mo),
        .i_borrow_in (w_b_st),
        .i_wrap      (BCD_MAX),
        .o_digit     (w_dec_mo),
        .o_borrow_out(w_b_mo)
    );

    bcd_digit_down u_dec_mt (
        .i_digit     (r_mt),
        .i_borrow_in (w_b_mo),
        .i_wrap      (BCD_MAX),
        .o_digit     (w_dec_mt),
        .o_borrow_out(w_b_mt)
    );

    assign w_time_zero = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
    assign w_dec_zero  = (w_dec_mt == 4'd0) && (w_dec_mo == 4'd0) &&
                         (w_dec_st == 4'd0) && (w_dec_so == 4'd0);

    // Next-state and next-value logic; priority door_open > stop > start > key > tick.
    always_comb begin
        w_state_next = r_state;
        w_mt_next    = r_mt;
        w_mo_next    = r_mo;
        w_st_next    = r_st;
        w_so_next    = r_so;
        w_count_next = r_count;
        case (r_state)
            ST_ENTRY: begin
                if (io_tmr.stop) begin
                    w_mt_next    = 4'd0;
                    w_mo_next    = 4'd0;
                    w_st_next    = 4'd0;
                    w_so_next    = 4'd0;
                    w_count_next = 3'd0;
                end else if (io_tmr.start && !io_tmr.door_open && !w_time_zero) begin
                    w_state_next = ST_RUN;
                end else if (io_tmr.key_valid && is_bcd(io_tmr.key_digit) && (r_count < MAX_CNT)) begin
                    w_mt_next    = r_mo;
                    w_mo_next    = r_st;
                    w_st_next    = r_so;
                    w_so_next    = io_tmr.key_digit;
                    w_count_next = r_count + 3'd1;
                end else begin
                    w_state_next = ST_ENTRY;
                end
            end
            ST_RUN: begin
                if (io_tmr.door_open || io_tmr.stop) begin
                    w_state_next = ST_PAUSE;
                end else if (io_tmr.tick_1hz) begin
                    // A borrow out of the top digit means the time was already zero.
                    if (w_b_mt) begin
                        w_mt_next    = 4'd0;
                        w_mo_next    = 4'd0;
                        w_st_next    = 4'd0;
                        w_so_next    = 4'd0;
                        w_state_next = ST_DONE;
                    end else begin
                        w_mt_next = w_dec_mt;
                        w_mo_next = w_dec_mo;
                        w_st_next = w_dec_st;
                        w_so_next = w_dec_so;
                        if (w_dec_zero) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_RUN;
                        end
                    end
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (io_tmr.door_open) begin
                    w_state_next = ST_PAUSE;
                end else if (io_tmr.stop) begin
                    w_state_next = ST_ENTRY;
                    w_mt_next    = 4'd0;
                    w_mo_next    = 4'd0;
                    w_st_next    = 4'd0;
                    w_so_next    = 4'd0;
                    w_count_next = 3'd0;
                end else if (io_tmr.start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (io_tmr.stop || io_tmr.key_valid) begin
                    w_state_next = ST_ENTRY;
                    w_mt_next    = 4'd0;
                    w_mo_next    = 4'd0;
                    w_st_next    = 4'd0;
                    w_so_next    = 4'd0;
                    w_count_next = 3'd0;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_ENTRY;
                w_mt_next    = 4'd0;
                w_mo_next    = 4'd0;
                w_st_next    = 4'd0;
                w_so_next    = 4'd0;
                w_count_next = 3'd0;
            end
        endcase
    end

    // State, time digits and status flags; flags follow the next state so they align with it.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state   <= ST_ENTRY;
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_count   <= 3'd0;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mt      <= w_mt_next;
            r_mo      <= w_mo_next;
            r_st      <= w_st_next;
            r_so      <= w_so_next;
            r_count   <= w_count_next;
            r_running <= (w_state_next == ST_RUN);
            r_paused  <= (w_state_next == ST_PAUSE);
            r_done    <= (w_state_next == ST_DONE);
        end
    end

    assign io_tmr.min_tens    = r_mt;
    assign io_tmr.min_ones    = r_mo;
    assign io_tmr.sec_tens    = r_st;
    assign io_tmr.sec_ones    = r_so;
    assign io_tmr.digit_count = r_count;
    assign io_tmr.running     = r_running;
    assign io_tmr.paused      = r_paused;
    assign io_tmr.done        = r_done;

endmodule

// File: doc/timer_digit_loader.md
Name: timer_digit_loader

Overview:
- Consumer end of the keypad strobe path: takes the single-cycle key-valid pulse plus a BCD digit, and shifts digits into a 4-digit MM:SS BCD register (microwave-style right entry).
- On start, counts the loaded time down once per 1 Hz tick and flags completion.
- Sits between the keypad/strobe counters and the display/magnetron control in timer_input_control.

Parameters:
- MAX_DIGITS, 4, number of key entries accepted before further digits are ignored (1..4).
- SEC_TENS_WRAP, 5, value loaded into seconds-tens on a borrow from minutes.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- key_valid  in  1  single-cycle strobe, digit present.
- key_digit  in  4  BCD digit; values >9 are invalid.
- start  in  1  level, sampled each cycle; start/resume.
- stop  in  1  level; pause, or cancel when already paused.
- door_open  in  1  level; forces pause while running.
- tick_1hz  in  1  single-cycle enable, one per second.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time value.
- digit_count  out  3  digits entered so far (0..MAX_DIGITS).
- running  out  1  high in RUN only.
- paused  out  1  high in PAUSE only.
- done  out  1  high in DONE state.

Behaviour:
- Reset (clear=1, async): all four digits=0, digit_count=0, state=ENTRY, running=paused=done=0. Applies mid-RUN with no completion pulse.
- States: ENTRY, RUN, PAUSE, DONE. All outputs are registered; state and outputs update on the edge after the causing input.
- Per-cycle priority: door_open > stop > start > key_valid > tick_1hz. Only the highest-priority applicable event acts in a given cycle.
- ENTRY:
  - key_valid with key_digit<=9 and digit_count<MAX_DIGITS: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit, digit_count+1.
  - key_digit>9 is ignored. Once full, further keys are ignored (no wrap, no overwrite).
  - start with door closed and time!=00:00 -> RUN. start with time=00:00 or door open is ignored.
  - stop clears digits and digit_count (stays in ENTRY).
- RUN:
  - tick_1hz decrements by one second with BCD borrow:
    - sec_ones>0: sec_ones-1.
    - else sec_ones=9 and sec_tens borrows: if >0 then -1, else sec_tens=SEC_TENS_WRAP and minutes borrow.
    - min_ones borrows from min_tens the same way (wrap 9).
  - Entered seconds-tens above 5 (e.g. 0:90) are legal and count down normally: 0:90 -> 0:89.
  - A tick arriving when time=00:01 gives 00:00 and -> DONE on the same edge.
  - door_open or stop -> PAUSE; value is held and that cycle's tick is dropped.
  - key_valid is ignored.
  - A tick in the same cycle as the start that entered RUN is not applied, because the decrement occurs only while the state is already RUN.
- PAUSE:
  - start with door closed -> RUN.
  - stop (door closed) -> ENTRY with digits and digit_count cleared.
  - Ticks and keys are ignored.
- DONE:
  - time=00:00, done=1 held.
  - stop or key_valid -> ENTRY with digit_count=0. The key that exits DONE is consumed, not shifted in.
  - start is ignored.
- Invariant: digits are never decremented below 00:00 and never leave BCD range, except for entered values the operator typed.

Decomposition:
- Package timer_pkg:
  - state enum (ENTRY, RUN, PAUSE, DONE).
  - 4-bit bcd_t typedef.
  - constants BCD_MAX=9, SEC_TENS_WRAP_DEF=5, MAX_DIGITS_DEF=4.
- One sub-module, bcd_digit_down:
  - inputs: digit, borrow_in, wrap value.
  - outputs: next digit, borrow_out.
  - combinational; instantiated four times in a ripple chain.

Test Plan:
- Keys 1,3,0 then start, 3 ticks -> display 01:30 after entry; running=1 the cycle after start; 01:27 after three ticks.
- Keys 9,9,9,9,5 -> display 99:99, digit_count=4; fifth key ignored. key_digit=12 at any time -> no change.
- Load 00:02, start, 2 ticks -> 00:01 then 00:00; done=1 and running=0 on the edge of the second tick. A further key_valid -> ENTRY, display 00:00, digit_count=0.
- Load 01:00, start, 1 tick -> 00:59 (minute borrow, sec_tens=5). Load 0:90 -> after one tick 0:89.
- Running at 00:45: door_open with simultaneous tick -> PAUSE at 00:45. Door closed + start -> RUN. stop twice -> PAUSE then ENTRY 00:00.
- Running at 05:10: assert clear asynchronously between edges -> outputs zero immediately, state ENTRY, no done pulse. start with 00:00 -> stays ENTRY.
